johnson_phase_sequencer: RTL

Controller that owns a WIDTH-stage Johnson (twisted-ring) counter and sequences it for a commanded number of full revolutions. It provides a start/done handshake, hold (pause) and abort control, and a one-hot decode of the 2·WIDTH phases for downstream multi-phase timing logic. It sits between a host control FSM and any logic that consumes phased enables.

---
 rtl/johnson_phase_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/johnson_phase_sequencer.sv
// Johnson (twisted-ring) counter sequencer: runs a commanded number of full
// revolutions with start/done handshake, hold/abort control and one-hot phase decode.
module johnson_phase_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     run_len_i,
    input  logic                 hold_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [WIDTH-1:0]     ring_o,
    output logic [2*WIDTH-1:0]   phase_o,
    output logic [IDX_W-1:0]     phase_idx_o,
    output logic [CNT_W-1:0]     rev_cnt_o
);

    localparam int unsigned         PHASES    = 2 * WIDTH;
    localparam logic [WIDTH-1:0]    RING_LAST = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE,
        S_ABORTED
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    ring_q, ring_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    rev_q, rev_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [PHASES-1:0]   phase_q, phase_d;

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ring_q    <= '0;
            idx_q     <= '0;
            rev_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            phase_q   <= '0;
        end else begin
            state_q   <= state_d;
            ring_q    <= ring_d;
            idx_q     <= idx_d;
            rev_q     <= rev_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            phase_q   <= phase_d;
        end
    end

    // Next-state logic; outputs are computed from the next state so they register cleanly
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        idx_d   = idx_q;
        rev_d   = rev_q;
        len_d   = len_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ring_d = '0;
                    idx_d  = '0;
                    rev_d  = '0;
                    if (run_len_i != '0) begin
                        len_d   = run_len_i;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    ring_d  = '0;
                    idx_d   = '0;
                    state_d = S_ABORTED;
                end else if (hold_i) begin
                    state_d = S_PAUSE;
                end else begin
                    ring_d = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
                    idx_d  = (idx_q == IDX_LAST) ? '0 : IDX_W'(idx_q + 1'b1);
                    if (ring_q == RING_LAST) begin
                        rev_d = CNT_W'(rev_q + 1'b1);
                        if (rev_d == len_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (abort_i) begin
                    ring_d  = '0;
                    idx_d   = '0;
                    state_d = S_ABORTED;
                end else if (!hold_i) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                ring_d  = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            S_ABORTED: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d    = (state_d == S_DONE);
        aborted_d = (state_d == S_ABORTED);
        phase_d   = '0;
        for (int k = 0; k < int'(PHASES); k++) begin
            phase_d[k] = busy_d && (idx_d == IDX_W'(k));
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign ring_o      = ring_q;
    assign phase_o     = phase_q;
    assign phase_idx_o = idx_q;
    assign rev_cnt_o   = rev_q;

endmodule
